camera_downsampler: RTL and testbench
=====================================

Name: camera_downsampler

Overview:
- Upstream stage of the image processor: captures the OV7670 byte stream (RGB565, two bytes per pixel) and packs each pixel into RGB332 (8-bit).
- Generates the write address and write enable for the dual-port frame buffer (176x144) that the VGA side reads and feeds to the image processor as PIXEL_IN.
- Runs entirely in the camera pixel-clock domain.

Parameters:
- SCREEN_WIDTH, 176, pixels per line written to the buffer.
- SCREEN_HEIGHT, 144, lines per frame written to the buffer.
- ADDR_W, 15, width of the buffer write address; must satisfy 2^ADDR_W >= SCREEN_WIDTH*SCREEN_HEIGHT.

Ports:
- CLK  in  1  camera pixel clock; every signal is sampled on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- CAM_DATA  in  8  camera byte bus.
- CAM_HREF  in  1  high while line data is valid.
- CAM_VSYNC  in  1  high during vertical blanking; a rising edge marks the end of a frame.
- PIXEL_OUT  out  8  RGB332 pixel {R[2:0],G[2:0],B[1:0]}.
- WRITE_ADDRESS  out  ADDR_W  buffer address = Y*SCREEN_WIDTH + X.
- W_EN  out  1  one-cycle write strobe, aligned with PIXEL_OUT and WRITE_ADDRESS.
- FRAME_DONE  out  1  one-cycle pulse on each CAM_VSYNC rising edge.

Behaviour:
- Reset values: PIXEL_OUT=0, WRITE_ADDRESS=0, W_EN=0, FRAME_DONE=0, X=0, Y=0, byte FSM=FIRST, href_d=0, vsync_d=0. Reset mid-line discards any partial pixel.
- Edge detection uses registered copies href_d and vsync_d, updated every cycle.
- Byte FSM has two states, FIRST and SECOND. It advances only on cycles where CAM_HREF=1 and CAM_VSYNC=0.
  - FIRST: latch hi_byte <= CAM_DATA, then go to SECOND.
  - SECOND: form PIXEL_OUT = {hi_byte[7:5], hi_byte[2:0], CAM_DATA[4:3]} and go to FIRST.
  - If X<SCREEN_WIDTH and Y<SCREEN_HEIGHT, also set WRITE_ADDRESS = Y*SCREEN_WIDTH+X and assert W_EN for exactly the next cycle.
  - X increments after every SECOND byte, saturating at SCREEN_WIDTH. Writes past the line width are suppressed, not wrapped.
- Write latency: W_EN, PIXEL_OUT and WRITE_ADDRESS are registered and valid in the cycle after the second byte is sampled.
- When CAM_HREF=0, the FSM holds; W_EN=0 except for a pending strobe from the previous cycle.
- HREF falling edge (href_d=1, CAM_HREF=0):
  - X <= 0 and FSM <= FIRST, so an odd trailing byte is dropped.
  - Y increments, saturating at SCREEN_HEIGHT; lines beyond SCREEN_HEIGHT are not written.
- VSYNC rising edge (vsync_d=0, CAM_VSYNC=1):
  - FRAME_DONE=1 for one cycle.
  - X<=0, Y<=0, FSM<=FIRST.
  - Any W_EN already scheduled for that cycle still completes.
- While CAM_VSYNC=1, all CAM_HREF activity is ignored: no writes, and X, Y and the FSM stay at their reset values.
- Simultaneous HREF fall and VSYNC rise: the VSYNC action wins (Y<=0, not incremented).
- Address arithmetic is done in ADDR_W bits. The maximum written address is SCREEN_WIDTH*SCREEN_HEIGHT-1 = 25343 and never exceeds it.
- No backpressure: the frame buffer always accepts a write when W_EN is high.

Test Plan:
- Reset: hold RESET for 3 cycles while CAM_HREF=1 and bytes toggle -> W_EN=0 and FRAME_DONE=0 throughout; all outputs 0 after release.
- Single pixel: VSYNC low, HREF high, bytes 0xE0 then 0x18 -> one cycle later W_EN=1, PIXEL_OUT=0xE3 (R=111, G=000, B=11), WRITE_ADDRESS=0.
- Line and address stepping: 2 lines of 176 pixels (352 bytes each), HREF low between lines -> 352 W_EN pulses total; last address 351; the first pixel of line 1 is at address 176.
- Overrun and odd byte: a line of 181 bytes, i.e. 90 pixels plus one stray -> 90 writes; the stray byte is dropped; the next line starts at X=0 with FSM=FIRST. A line of 400 bytes -> only 176 writes.
- Frame boundary: VSYNC pulse after 144 lines -> FRAME_DONE is one cycle wide; next frame's first write is at address 0. A 145th line -> no writes; the maximum address seen is 25343.
- VSYNC blanking: CAM_HREF toggled with bytes while CAM_VSYNC=1 -> zero W_EN pulses. HREF fall coincident with VSYNC rise -> Y=0 afterward.

Source files
------------

// File: rtl/camera_downsampler.sv
// rtl/camera_downsampler.sv - OV7670 RGB565 byte stream to RGB332 frame-buffer writer
module camera_downsampler #(
    parameter int SCREEN_WIDTH  = 176,
    parameter int SCREEN_HEIGHT = 144,
    parameter int ADDR_W        = 15
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [7:0]        CAM_DATA,
    input  logic              CAM_HREF,
    input  logic              CAM_VSYNC,
    output logic [7:0]        PIXEL_OUT,
    output logic [ADDR_W-1:0] WRITE_ADDRESS,
    output logic              W_EN,
    output logic              FRAME_DONE
);

    localparam int X_W = $clog2(SCREEN_WIDTH + 1);
    localparam int Y_W = $clog2(SCREEN_HEIGHT + 1);
    localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_WIDTH);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_HEIGHT);

    typedef enum logic {FIRST, SECOND} byte_state_t;

    byte_state_t       state;
    logic [7:0]        hi_byte;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic              href_d;
    logic              vsync_d;
    logic [ADDR_W-1:0] wr_addr;
    logic              in_bounds;

    assign wr_addr   = ADDR_W'(y) * ADDR_W'(SCREEN_WIDTH) + ADDR_W'(x);
    assign in_bounds = (x < X_MAX) && (y < Y_MAX);

    // Byte pairing, X/Y position tracking and registered write/frame strobes
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= FIRST;
            hi_byte       <= 8'h00;
            x             <= '0;
            y             <= '0;
            href_d        <= 1'b0;
            vsync_d       <= 1'b0;
            PIXEL_OUT     <= 8'h00;
            WRITE_ADDRESS <= '0;
            W_EN          <= 1'b0;
            FRAME_DONE    <= 1'b0;
        end else begin
            href_d     <= CAM_HREF;
            vsync_d    <= CAM_VSYNC;
            W_EN       <= 1'b0;
            FRAME_DONE <= 1'b0;

            if (CAM_VSYNC) begin
                // Blanking: position is parked at the origin; the rising edge flags end of frame
                if (!vsync_d) begin
                    FRAME_DONE <= 1'b1;
                end
                x     <= '0;
                y     <= '0;
                state <= FIRST;
            end else if (href_d && !CAM_HREF) begin
                // End of line: an odd trailing byte is dropped by restarting at FIRST
                x     <= '0;
                state <= FIRST;
                if (y < Y_MAX) begin
                    y <= y + 1'b1;
                end
            end else if (CAM_HREF) begin
                if (state == FIRST) begin
                    hi_byte <= CAM_DATA;
                    state   <= SECOND;
                end else begin
                    PIXEL_OUT <= {hi_byte[7:5], hi_byte[2:0], CAM_DATA[4:3]};
                    state     <= FIRST;
                    if (in_bounds) begin
                        WRITE_ADDRESS <= wr_addr;
                        W_EN          <= 1'b1;
                    end
                    if (x < X_MAX) begin
                        x <= x + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_camera_downsampler.sv
// tb/tb_camera_downsampler.sv - directed table and sequence bench for camera_downsampler
module tb_camera_downsampler;

    logic        clk;
    logic        reset;
    logic [7:0]  cam_data;
    logic        cam_href;
    logic        cam_vsync;
    logic [7:0]  pixel_out;
    logic [14:0] write_address;
    logic        w_en;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    int          wcount;
    int          fdcount;
    logic [14:0] last_addr;
    logic [14:0] max_addr;
    logic [14:0] nth_addr;
    logic [7:0]  nth_pix;
    int          nth_target;

    camera_downsampler dut (
        .CLK           (clk),
        .RESET         (reset),
        .CAM_DATA      (cam_data),
        .CAM_HREF      (cam_href),
        .CAM_VSYNC     (cam_vsync),
        .PIXEL_OUT     (pixel_out),
        .WRITE_ADDRESS (write_address),
        .W_EN          (w_en),
        .FRAME_DONE    (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        href;
        logic        vsync;
        logic        wen;
        logic [7:0]  pix;
        logic [14:0] addr;
        logic        fd;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and observe outputs just after the edge
    task automatic tick(input logic [7:0] d, input logic h, input logic v);
        cam_data  = d;
        cam_href  = h;
        cam_vsync = v;
        @(posedge clk);
        #1;
        if (frame_done === 1'b1) fdcount++;
        if (w_en === 1'b1) begin
            wcount++;
            last_addr = write_address;
            if (write_address > max_addr) max_addr = write_address;
            if (wcount == nth_target) begin
                nth_addr = write_address;
                nth_pix  = pixel_out;
            end
        end
    endtask

    task automatic line(input int nbytes);
        for (int i = 0; i < nbytes; i++) tick(i[7:0], 1'b1, 1'b0);
        tick(8'h00, 1'b0, 1'b0);
        tick(8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) tick(8'(i * 37), 1'b1, 1'b0);
        reset = 1'b0;
        wcount = 0; fdcount = 0; last_addr = '0; max_addr = '0; nth_target = 0;
    endtask

    initial begin
        reset = 1'b1; cam_data = 8'h00; cam_href = 1'b0; cam_vsync = 1'b0;
        wcount = 0; fdcount = 0; last_addr = '0; max_addr = '0;
        nth_addr = '0; nth_pix = '0; nth_target = 0;

        //           data   href  vsync wen   pix    addr    fd
        vecs[0]  = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 15'd0,   1'b0};
        vecs[1]  = '{8'hE0, 1'b1, 1'b0, 1'b0, 8'h00, 15'd0,   1'b0};
        vecs[2]  = '{8'h18, 1'b1, 1'b0, 1'b1, 8'hE3, 15'd0,   1'b0};
        vecs[3]  = '{8'h55, 1'b1, 1'b0, 1'b0, 8'hE3, 15'd0,   1'b0};
        vecs[4]  = '{8'hAA, 1'b1, 1'b0, 1'b1, 8'h55, 15'd1,   1'b0};
        vecs[5]  = '{8'hFF, 1'b1, 1'b0, 1'b0, 8'h55, 15'd1,   1'b0};
        vecs[6]  = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h55, 15'd1,   1'b0};
        vecs[7]  = '{8'h12, 1'b1, 1'b0, 1'b0, 8'h55, 15'd1,   1'b0};
        vecs[8]  = '{8'h34, 1'b1, 1'b0, 1'b1, 8'h0A, 15'd176, 1'b0};
        vecs[9]  = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h0A, 15'd176, 1'b0};
        vecs[10] = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h0A, 15'd176, 1'b1};
        vecs[11] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h0A, 15'd176, 1'b0};
        vecs[12] = '{8'h77, 1'b1, 1'b1, 1'b0, 8'h0A, 15'd176, 1'b0};
        vecs[13] = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h0A, 15'd176, 1'b0};
        vecs[14] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h0A, 15'd176, 1'b0};
        vecs[15] = '{8'h9C, 1'b1, 1'b0, 1'b0, 8'h0A, 15'd176, 1'b0};
        vecs[16] = '{8'h5B, 1'b1, 1'b0, 1'b1, 8'h93, 15'd0,   1'b0};
        vecs[17] = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h93, 15'd0,   1'b1};
        vecs[18] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h93, 15'd0,   1'b0};
        vecs[19] = '{8'h01, 1'b1, 1'b0, 1'b0, 8'h93, 15'd0,   1'b0};
        vecs[20] = '{8'h02, 1'b1, 1'b0, 1'b1, 8'h04, 15'd0,   1'b0};
        vecs[21] = '{8'h03, 1'b1, 1'b0, 1'b0, 8'h04, 15'd0,   1'b0};
        vecs[22] = '{8'h04, 1'b1, 1'b0, 1'b1, 8'h0C, 15'd1,   1'b0};
        vecs[23] = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h0C, 15'd1,   1'b1};

        // Reset held while bytes stream: no strobes may appear
        for (int i = 0; i < 3; i++) begin
            tick(8'(8'hA5 ^ i[7:0]), 1'b1, 1'b0);
            chk($sformatf("reset_quiet_%0d", i), {30'd0, w_en, frame_done}, 32'd0);
        end
        reset = 1'b0;

        // Cycle-by-cycle table; record layout {W_EN, PIXEL_OUT, WRITE_ADDRESS, FRAME_DONE}
        for (int i = 0; i < 24; i++) begin
            tick(vecs[i].data, vecs[i].href, vecs[i].vsync);
            chk($sformatf("vec_%0d", i),
                {7'd0, w_en, pixel_out, write_address, frame_done},
                {7'd0, vecs[i].wen, vecs[i].pix, vecs[i].addr, vecs[i].fd});
        end

        // Two full lines: address stepping across the line boundary
        do_reset();
        nth_target = 177;
        line(352);
        line(352);
        chk("two_lines_writes", wcount, 352);
        chk("two_lines_last_addr", {17'd0, last_addr}, 32'd351);
        chk("line1_first_addr", {17'd0, nth_addr}, 32'd176);

        // Odd-length line, realignment of the next line, then an overlong line
        do_reset();
        line(181);
        chk("odd_line_writes", wcount, 90);
        nth_target = 91;
        tick(8'hE0, 1'b1, 1'b0);
        tick(8'h18, 1'b1, 1'b0);
        tick(8'h00, 1'b0, 1'b0);
        chk("realign_addr", {17'd0, nth_addr}, 32'd176);
        chk("realign_pix", {24'd0, nth_pix}, 32'hE3);
        wcount = 0;
        line(400);
        chk("overlong_line_writes", wcount, 176);
        chk("overlong_last_addr", {17'd0, last_addr}, 32'd527);

        // Full frame, an extra 145th line, then the frame boundary
        do_reset();
        for (int l = 0; l < 144; l++) line(352);
        chk("frame_writes", wcount, 25344);
        chk("frame_max_addr", {17'd0, max_addr}, 32'd25343);
        line(352);
        chk("line145_writes", wcount, 25344);
        chk("line145_max_addr", {17'd0, max_addr}, 32'd25343);
        fdcount = 0;
        for (int i = 0; i < 4; i++) tick(8'h00, 1'b0, 1'b1);
        chk("frame_done_width", fdcount, 1);

        // Blanking: HREF and bytes toggling under VSYNC produce nothing
        wcount = 0;
        for (int i = 0; i < 40; i++) tick(i[7:0], i[2], 1'b1);
        tick(8'h00, 1'b0, 1'b1);
        tick(8'h00, 1'b0, 1'b0);
        chk("blanking_writes", wcount, 0);
        nth_target = 1;
        line(4);
        chk("new_frame_first_addr", {17'd0, nth_addr}, 32'd0);
        chk("new_frame_writes", wcount, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
